// File: rtl/is_pkg.sv
// Shared types for the interval-score synchronisation point: point states and per-arc status.
package is_pkg;

    localparam int unsigned MAX_N_IN = 16;

    typedef enum logic [4:0] {
        WAIT_MIN = 5'b00001,
        ARMED    = 5'b00010,
        FIRED    = 5'b00100,
        SKIPPED  = 5'b01000,
        KILLED   = 5'b10000
    } point_state_t;

    typedef struct packed {
        logic min;
        logic max;
        logic skip;
        logic kill;
    } arc_status_t;

endpackage

// File: rtl/arc_tracker.sv
// Sticky status latch for one incoming interval slot; bits only ever set until reset.
module arc_tracker
    import is_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  arc_status_t evt,
    output arc_status_t status
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status <= '0;
        end else if (en) begin
            status <= arc_status_t'(status | evt);
        end
    end

endmodule

// File: rtl/event_point.sv
// Synchronisation point: reduces incoming arc status and decides fire / skip / kill once per reset.
module event_point
    import is_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned N_IN        = 4,
    parameter bit          INTERACTIVE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IN-1:0]  in_en,
    input  logic [N_IN-1:0]  in_min,
    input  logic [N_IN-1:0]  in_max,
    input  logic [N_IN-1:0]  in_skip,
    input  logic [N_IN-1:0]  in_kill,
    input  logic             trigger,
    input  logic [WIDTH-1:0] global_clock,
    output logic             start,
    output logic             skip_p,
    output logic             kill_p,
    output logic             fired,
    output logic [WIDTH-1:0] fire_time
);

    if (N_IN == 0 || N_IN > MAX_N_IN) begin : g_n_in_check
        $error("event_point: N_IN out of range");
    end

    arc_status_t       evt    [N_IN];
    arc_status_t       flag   [N_IN];
    logic [N_IN-1:0]   cur_min;
    logic [N_IN-1:0]   cur_max;
    logic [N_IN-1:0]   cur_skip;
    logic [N_IN-1:0]   cur_kill;

    // Per-slot view: registered sticky flags OR this cycle's inputs, gated by the slot mask
    for (genvar g = 0; g < N_IN; g++) begin : g_arc
        assign evt[g] = '{min: in_min[g], max: in_max[g], skip: in_skip[g], kill: in_kill[g]};

        arc_tracker u_arc (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (in_en[g]),
            .evt    (evt[g]),
            .status (flag[g])
        );

        assign cur_min[g]  = in_en[g] & (flag[g].min  | in_min[g]);
        assign cur_max[g]  = in_en[g] & (flag[g].max  | in_max[g]);
        assign cur_skip[g] = in_en[g] & (flag[g].skip | in_skip[g]);
        assign cur_kill[g] = in_en[g] & (flag[g].kill | in_kill[g]);
    end

    logic all_res;
    logic all_skip;
    logic any_kill;
    logic any_max;
    logic can_arm;

    assign all_res  = &(cur_min | cur_skip | ~in_en);
    assign all_skip = (&(cur_skip | ~in_en)) & (|in_en);
    assign any_kill = |cur_kill;
    assign any_max  = |(cur_max & ~cur_skip);
    // A root point (empty mask) arms unconditionally; otherwise at least one real minimum is needed
    assign can_arm  = all_res & ((|cur_min) | ~(|in_en));

    point_state_t state;
    point_state_t next_state;
    logic         fire_now;

    always_comb begin
        next_state = state;
        fire_now   = 1'b0;
        case (state)
            WAIT_MIN: begin
                if (any_kill)      next_state = KILLED;
                else if (all_skip) next_state = SKIPPED;
                else if (can_arm)  next_state = ARMED;
            end
            ARMED: begin
                if (any_kill) begin
                    next_state = KILLED;
                end else if (all_skip) begin
                    next_state = SKIPPED;
                end else if (!INTERACTIVE || trigger || any_max) begin
                    next_state = FIRED;
                    fire_now   = 1'b1;
                end
            end
            default: next_state = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= WAIT_MIN;
            start     <= 1'b0;
            skip_p    <= 1'b0;
            kill_p    <= 1'b0;
            fired     <= 1'b0;
            fire_time <= '0;
        end else begin
            state  <= next_state;
            start  <= fire_now;
            fired  <= fired | fire_now;
            skip_p <= (next_state == SKIPPED);
            kill_p <= (next_state == KILLED);
            if (fire_now) begin
                fire_time <= global_clock;
            end
        end
    end

endmodule

// File: tb/tb_event_point.sv
// Randomised bench for event_point: one interactive and one static instance share stimulus.
module tb_event_point;

    localparam int unsigned W = 32;
    localparam int unsigned N = 4;

    localparam int P_WAIT = 0;
    localparam int P_ARM  = 1;
    localparam int P_FIRE = 2;
    localparam int P_SKIP = 3;
    localparam int P_KILL = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] in_en = '0;
    logic [N-1:0] in_min = '0;
    logic [N-1:0] in_max = '0;
    logic [N-1:0] in_skip = '0;
    logic [N-1:0] in_kill = '0;
    logic         trigger = 1'b0;
    logic [W-1:0] global_clock;

    logic         start_v     [2];
    logic         skip_p_v    [2];
    logic         kill_p_v    [2];
    logic         fired_v     [2];
    logic [W-1:0] fire_time_v [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    initial global_clock = $urandom;
    always @(posedge clk) global_clock <= global_clock + 32'd1;

    event_point #(.WIDTH(W), .N_IN(N), .INTERACTIVE(1'b1)) u_int (
        .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_min(in_min), .in_max(in_max),
        .in_skip(in_skip), .in_kill(in_kill), .trigger(trigger), .global_clock(global_clock),
        .start(start_v[0]), .skip_p(skip_p_v[0]), .kill_p(kill_p_v[0]),
        .fired(fired_v[0]), .fire_time(fire_time_v[0])
    );

    event_point #(.WIDTH(W), .N_IN(N), .INTERACTIVE(1'b0)) u_sta (
        .clk(clk), .rst_n(rst_n), .in_en(in_en), .in_min(in_min), .in_max(in_max),
        .in_skip(in_skip), .in_kill(in_kill), .trigger(trigger), .global_clock(global_clock),
        .start(start_v[1]), .skip_p(skip_p_v[1]), .kill_p(kill_p_v[1]),
        .fired(fired_v[1]), .fire_time(fire_time_v[1])
    );

    // Reference: what each arc has reported so far, and the outcome of each point
    bit           seen_min  [N];
    bit           seen_max  [N];
    bit           seen_skip [N];
    bit           seen_kill [N];
    int           phase     [2];
    bit           exp_start [2];
    logic [W-1:0] exp_ft    [2];

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) begin
            seen_min[i] = 0; seen_max[i] = 0; seen_skip[i] = 0; seen_kill[i] = 0;
        end
        for (int k = 0; k < 2; k++) begin
            phase[k] = P_WAIT; exp_start[k] = 0; exp_ft[k] = '0;
        end
    endtask

    // Outcome of the coming clock edge given the inputs now on the pins
    task automatic model_step();
        int  n_en = 0, n_res = 0, n_skip = 0, n_min = 0;
        bit  kill_seen = 0, live_max = 0;
        bit  m, x, s, kl;
        for (int i = 0; i < int'(N); i++) begin
            if (in_en[i]) begin
                m  = seen_min[i]  | in_min[i];
                x  = seen_max[i]  | in_max[i];
                s  = seen_skip[i] | in_skip[i];
                kl = seen_kill[i] | in_kill[i];
                n_en++;
                if (m || s) n_res++;
                if (s) n_skip++;
                if (m) n_min++;
                if (kl) kill_seen = 1;
                if (x && !s) live_max = 1;
            end
        end
        for (int k = 0; k < 2; k++) begin
            exp_start[k] = 0;
            if (phase[k] == P_WAIT) begin
                if (kill_seen) phase[k] = P_KILL;
                else if (n_en > 0 && n_skip == n_en) phase[k] = P_SKIP;
                else if (n_res == n_en && (n_min > 0 || n_en == 0)) phase[k] = P_ARM;
            end else if (phase[k] == P_ARM) begin
                if (kill_seen) phase[k] = P_KILL;
                else if (n_en > 0 && n_skip == n_en) phase[k] = P_SKIP;
                else if (k == 1 || trigger || live_max) begin
                    phase[k]     = P_FIRE;
                    exp_start[k] = 1;
                    exp_ft[k]    = global_clock;
                end
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (in_en[i]) begin
                seen_min[i]  |= in_min[i];
                seen_max[i]  |= in_max[i];
                seen_skip[i] |= in_skip[i];
                seen_kill[i] |= in_kill[i];
            end
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("d%0d.start", k),     W'(start_v[k]),  W'(exp_start[k]));
            check($sformatf("d%0d.fired", k),     W'(fired_v[k]),  W'(phase[k] == P_FIRE));
            check($sformatf("d%0d.skip_p", k),    W'(skip_p_v[k]), W'(phase[k] == P_SKIP));
            check($sformatf("d%0d.kill_p", k),    W'(kill_p_v[k]), W'(phase[k] == P_KILL));
            check($sformatf("d%0d.fire_time", k), fire_time_v[k],  exp_ft[k]);
        end
    endtask

    function automatic logic [N-1:0] rnd_bits(input int pct);
        logic [N-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        for (int ep = 0; ep < 80; ep++) begin
            int len;
            int kill_pct;
            // Asynchronous reset asserted between edges, mid-episode
            @(negedge clk);
            #2;
            rst_n   = 1'b0;
            in_min  = '0; in_max = '0; in_skip = '0; in_kill = '0; trigger = 1'b0;
            #1;
            model_reset();
            check_outputs();
            @(negedge clk);
            in_en    = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom_range(1, 15));
            kill_pct = ($urandom_range(0, 2) == 0) ? 4 : 0;
            len      = $urandom_range(5, 45);
            rst_n    = 1'b1;
            for (int c = 0; c < len; c++) begin
                check_outputs();
                in_min  = rnd_bits(15);
                in_max  = rnd_bits(6);
                in_skip = rnd_bits(5);
                in_kill = rnd_bits(kill_pct);
                trigger = ($urandom_range(0, 99) < 12);
                model_step();
                @(negedge clk);
            end
            check_outputs();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
